// File: rtl/mean_sample_feeder.sv
// Sample feeder for running_mean: buffers upstream samples in a FIFO and issues
// them as single-cycle strobes separated by GAP idle cycles, flagging full windows.
module mean_sample_feeder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WINDOW_SIZE = 8,
  parameter int unsigned GAP         = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid_out,
  output logic                        window_done,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(WINDOW_SIZE);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_SIZE - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_q;
  logic [GW-1:0]           gap_q, gap_d;
  logic [WW-1:0]           win_q;
  logic                    has_data;
  logic                    push;
  logic                    issue;

  assign has_data = (count_q != '0);
  assign s_ready  = (count_q < FULL) && !flush;
  assign push     = s_valid && s_ready;
  assign count    = count_q;
  assign busy     = has_data || (state_q != S_IDLE);

  // issue doubles as the FIFO pop; it is only raised when count is non-zero
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (has_data) begin
          issue   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (GAP > 0) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end else if (has_data) begin
          issue   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (has_data) begin
          issue   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      gap_d   = '0;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, issue})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // data_out is deliberately left untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      window_done <= 1'b0;
      win_q       <= '0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      window_done <= 1'b0;
      win_q       <= '0;
    end else begin
      valid_out   <= issue;
      window_done <= issue && (win_q == WIN_LAST);
      if (issue) begin
        data_out <= mem[rd_ptr];
        win_q    <= win_q + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mean_sample_feeder.sv
// Bench for mean_sample_feeder: two instances (GAP=1 and GAP=0) checked every
// cycle against a queue/timestamp model, plus directed literal expectations.
module tb_mean_sample_feeder;

  localparam int DEPTH = 8;
  localparam int WIN   = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] s_data      [2];
  logic        s_valid     [2];
  logic        flush       [2];
  logic        s_ready     [2];
  logic [15:0] data_out    [2];
  logic        valid_out   [2];
  logic        window_done [2];
  logic [3:0]  count       [2];
  logic        busy        [2];

  always #5 clk = ~clk;

  mean_sample_feeder #(.DATA_WIDTH(16), .DEPTH(8), .WINDOW_SIZE(8), .GAP(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .flush(flush[0]), .data_out(data_out[0]),
    .valid_out(valid_out[0]), .window_done(window_done[0]), .count(count[0]),
    .busy(busy[0])
  );

  mean_sample_feeder #(.DATA_WIDTH(16), .DEPTH(8), .WINDOW_SIZE(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .flush(flush[1]), .data_out(data_out[1]),
    .valid_out(valid_out[1]), .window_done(window_done[1]), .count(count[1]),
    .busy(busy[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0d expected=%0d", nm, i, got, exp);
    end
  endtask

  function automatic int gapv(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Model: FIFO as an unbounded buffer, issues spaced at least GAP+1 edges apart
  int m_buf [2][256];
  int m_rd [2], m_wr [2], m_last [2], m_ec [2], m_win [2], m_data [2];
  bit m_valid [2], m_wd [2];

  always @(posedge clk or negedge rst_n) begin : model
    int cnt;
    bit do_pop, do_push;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_rd[i] = 0; m_wr[i] = 0; m_ec[i] = 0; m_win[i] = 0; m_data[i] = 0;
        m_last[i] = -1000; m_valid[i] = 1'b0; m_wd[i] = 1'b0;
      end else begin
        m_ec[i]++;
        if (flush[i]) begin
          m_rd[i] = m_wr[i]; m_win[i] = 0; m_last[i] = -1000;
          m_valid[i] = 1'b0; m_wd[i] = 1'b0;
        end else begin
          cnt     = m_wr[i] - m_rd[i];
          do_pop  = (cnt > 0) && (m_ec[i] - m_last[i] >= gapv(i) + 1);
          do_push = s_valid[i] && (cnt < DEPTH);
          if (do_pop) begin
            m_data[i]  = m_buf[i][m_rd[i] % 256];
            m_rd[i]++;
            m_valid[i] = 1'b1;
            m_win[i]   = (m_win[i] + 1) % WIN;
            m_wd[i]    = (m_win[i] == 0);
            m_last[i]  = m_ec[i];
          end else begin
            m_valid[i] = 1'b0;
            m_wd[i]    = 1'b0;
          end
          if (do_push) begin
            m_buf[i][m_wr[i] % 256] = int'(s_data[i]);
            m_wr[i]++;
          end
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  int lg_d [2][64];
  int lg_w [2][64];
  int lg_c [2][64];
  int nlog [2];

  always @(negedge clk) begin : compare
    int cnt;
    bit eb;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        cnt = m_wr[i] - m_rd[i];
        eb  = (cnt != 0) || (m_ec[i] - m_last[i] <= gapv(i));
        chk("valid_out", i, 32'(valid_out[i]), 32'(m_valid[i]));
        chk("data_out", i, 32'(data_out[i]), 32'(m_data[i]));
        chk("window_done", i, 32'(window_done[i]), 32'(m_wd[i]));
        chk("count", i, 32'(count[i]), 32'(cnt));
        chk("s_ready", i, 32'(s_ready[i]), 32'((cnt < DEPTH) && !flush[i]));
        chk("busy", i, 32'(busy[i]), 32'(eb));
        if (valid_out[i] === 1'b1 && nlog[i] < 64) begin
          lg_d[i][nlog[i]] = int'(data_out[i]);
          lg_w[i][nlog[i]] = int'(window_done[i]);
          lg_c[i][nlog[i]] = cyc;
          nlog[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog dut0 got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, v, n_at, guard;
    bit rdy, saw_full, fl, found;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; flush[i] = 1'b0; nlog[i] = 0;
    end
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    idle(2);
    rst_n = 1'b1;

    // reset then idle
    idle(5);
    chk("idle_pulses", 0, 32'(nlog[0]), 0);
    chk("idle_busy", 0, 32'(busy[0]), 0);
    chk("idle_ready", 0, 32'(s_ready[0]), 1);

    // eight-sample window, GAP=1
    nlog[0] = 0;
    c0 = cyc;
    for (int k = 1; k <= 8; k++) begin
      s_valid[0] = 1'b1; s_data[0] = 16'(10 * k);
      step();
    end
    s_valid[0] = 1'b0;
    idle(12);
    chk("win_npulses", 0, 32'(nlog[0]), 8);
    chk("win_latency", 0, 32'(lg_c[0][0] - c0), 2);
    for (int k = 0; k < 8; k++) begin
      chk("win_data", 0, 32'(lg_d[0][k]), 32'(10 * (k + 1)));
      chk("win_done", 0, 32'(lg_w[0][k]), 32'(k == 7));
      if (k > 0) chk("win_spacing", 0, 32'(lg_c[0][k] - lg_c[0][k-1]), 2);
    end
    chk("win_count_end", 0, 32'(count[0]), 0);
    chk("win_busy_end", 0, 32'(busy[0]), 0);

    // back-pressure, values 1..20
    nlog[0] = 0; v = 1; saw_full = 1'b0; guard = 0;
    s_valid[0] = 1'b1;
    while (v <= 20 && guard < 200) begin
      s_data[0] = 16'(v);
      rdy = s_ready[0];
      if (!rdy) begin
        saw_full = 1'b1;
        chk("bp_full_count", 0, 32'(count[0]), 8);
      end
      step();
      if (rdy) v++;
      guard++;
    end
    s_valid[0] = 1'b0;
    idle(30);
    chk("bp_all_pushed", 0, 32'(v), 21);
    chk("bp_saw_full", 0, 32'(saw_full), 1);
    chk("bp_npulses", 0, 32'(nlog[0]), 20);
    for (int k = 0; k < 20; k++) begin
      chk("bp_data", 0, 32'(lg_d[0][k]), 32'(k + 1));
      chk("bp_done", 0, 32'(lg_w[0][k]), 32'((k + 1 == 8) || (k + 1 == 16)));
    end

    // back-to-back, GAP=0
    nlog[1] = 0;
    c0 = cyc;
    for (int k = 5; k <= 7; k++) begin
      s_valid[1] = 1'b1; s_data[1] = 16'(k);
      step();
    end
    s_valid[1] = 1'b0;
    idle(6);
    chk("b2b_npulses", 1, 32'(nlog[1]), 3);
    chk("b2b_latency", 1, 32'(lg_c[1][0] - c0), 2);
    for (int k = 0; k < 3; k++) begin
      chk("b2b_data", 1, 32'(lg_d[1][k]), 32'(k + 5));
      if (k > 0) chk("b2b_consecutive", 1, 32'(lg_c[1][k] - lg_c[1][k-1]), 1);
    end
    chk("b2b_busy_end", 1, 32'(busy[1]), 0);

    // flush mid-stream (window counter sits at 28 mod 8 = 4 beforehand)
    nlog[0] = 0; fl = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s_valid[0] = 1'b1; s_data[0] = 16'(k);
      if (nlog[0] >= 2 && !fl) begin
        flush[0] = 1'b1; fl = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("flush_count", 0, 32'(count[0]), 0);
        chk("flush_valid", 0, 32'(valid_out[0]), 0);
      end else begin
        step();
      end
    end
    s_valid[0] = 1'b0;
    chk("flush_fired", 0, 32'(fl), 1);
    n_at = nlog[0];
    idle(10);
    chk("flush_no_more", 0, 32'(nlog[0]), 32'(n_at));
    chk("flush_pulses", 0, 32'(n_at), 2);
    s_valid[0] = 1'b1; s_data[0] = 16'd99;
    step();
    s_valid[0] = 1'b0;
    idle(4);
    chk("post_flush_n", 0, 32'(nlog[0]), 3);
    chk("post_flush_99", 0, 32'(lg_d[0][2]), 99);
    chk("post_flush_wd", 0, 32'(lg_w[0][2]), 0);
    for (int k = 100; k <= 106; k++) begin
      s_valid[0] = 1'b1; s_data[0] = 16'(k);
      step();
    end
    s_valid[0] = 1'b0;
    idle(20);
    chk("post_flush_n2", 0, 32'(nlog[0]), 10);
    for (int k = 3; k < 10; k++) begin
      chk("post_flush_data", 0, 32'(lg_d[0][k]), 32'(97 + k));
      chk("post_flush_done", 0, 32'(lg_w[0][k]), 32'(k == 9));
    end

    // async reset with 4 queued and valid_out high
    found = 1'b0;
    for (int k = 1; k <= 12 && !found; k++) begin
      s_valid[0] = 1'b1; s_data[0] = 16'(k);
      step();
      if (valid_out[0] === 1'b1 && count[0] == 4'd4) found = 1'b1;
    end
    chk("async_setup", 0, 32'(found), 1);
    #2;
    s_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 0, 32'(valid_out[0]), 0);
    chk("async_count", 0, 32'(count[0]), 0);
    chk("async_data", 0, 32'(data_out[0]), 0);
    chk("async_busy", 0, 32'(busy[0]), 0);
    chk("async_wd", 0, 32'(window_done[0]), 0);
    idle(2);
    rst_n = 1'b1;
    nlog[0] = 0;
    idle(5);
    chk("after_reset_pulses", 0, 32'(nlog[0]), 0);
    chk("after_reset_busy", 0, 32'(busy[0]), 0);
    chk("after_reset_ready", 0, 32'(s_ready[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
